sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexes one shared combinational hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Accepts a packed multi-digit hex value over a valid/ready handshake and double-buffers it so digit contents change only at frame boundaries.
- Sequences digit select, anti-ghosting blanking and optional leading-zero suppression.
- Sits between the display-value producer and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; 2..8.
- REFRESH_DIV, 50000: clock cycles per digit dwell; must be >= 2.
- BLANK_CYCLES, 2: cycles at the start of each dwell with all anodes off; 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; 0 forces IDLE.
- lz_suppress  in  1  1 = blank leading zero digits.
- load_valid  in  1  new value offered.
- load_data  in  4*NUM_DIGITS  packed nibbles; nibble k drives digit k; digit 0 is least significant and rightmost.
- load_ready  out  1  pending buffer empty; load accepted when valid && ready.
- nibble_out  out  4  registered nibble to the shared decoder input.
- seg_in  in  7  decoder output for nibble_out; bit6=a .. bit0=g, active-high.
- seg_out  out  7  segments to pins, active-high.
- an_out  out  NUM_DIGITS  anodes, active-low, one-hot-low or all high.
- frame_done  out  1  one-cycle pulse when digit NUM_DIGITS-1 dwell ends.

Behaviour:
- Reset (async, reset_n=0) sets:
  - state=IDLE, digit_idx=0, dwell counter=0.
  - display and pending buffers = 0, pending_full=0, load_ready=1.
  - nibble_out=0, an_out=all 1, seg_out=0, frame_done=0.
- Reset asserted mid-dwell takes effect immediately; no completion of the current dwell.
- States and transitions:
  - IDLE: anodes all high, seg_out=0. enable=1 -> BLANK with digit_idx=0, counter=0.
  - BLANK: anodes all high, seg_out=0, counter counts 0..BLANK_CYCLES-1. Entering BLANK registers nibble_out = display nibble digit_idx, so the decoder settles before the anode is driven. Exit at counter=BLANK_CYCLES-1 -> ON.
  - ON: an_out[digit_idx]=0, seg_out=seg_in, unless this digit is suppressed (anode stays high, seg_out=0). Exit at counter=REFRESH_DIV-1 -> BLANK of the next digit.
- Dwell length: exactly REFRESH_DIV cycles per digit (BLANK + ON). Frame length = NUM_DIGITS*REFRESH_DIV cycles.
- Wrap-around: digit_idx NUM_DIGITS-1 -> 0; frame_done pulses on the last ON cycle of digit NUM_DIGITS-1.
- Double buffering:
  - An accepted load writes the pending buffer and sets pending_full; load_ready=0 while pending_full.
  - Frame boundary transfer happens on entry to BLANK of digit 0, including first entry from IDLE: if pending_full, display <= pending and pending_full clears. load_ready returns to 1 the following cycle.
  - A load presented while load_ready=0 is ignored and must be held by the producer.
  - Load accepted in the same cycle as a transfer is impossible, since ready=0 whenever a transfer can occur.
- Leading-zero suppression, evaluated on the display buffer:
  - Digit k is suppressed when lz_suppress=1, k>0, and nibbles k..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed.
  - lz_suppress is sampled on BLANK entry for each digit.
- enable deassert in any non-IDLE state -> IDLE on the next edge; anodes high that edge. digit_idx and counter clear; pending buffer and pending_full are retained. Loads are still accepted in IDLE.
- nibble_out is the only input to the decoder; seg_in is combinational and is assumed valid one cycle after nibble_out changes.

Test Plan:
(NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless noted)
- Reset: hold reset_n=0 -> an_out=4'b1111, seg_out=0, load_ready=1, frame_done=0. Release with enable=0 -> outputs unchanged indefinitely.
- Basic scan: load 16'h1234, then enable=1 ->
  - nibble_out sequence 4,3,2,1 repeating.
  - Each digit: 2 cycles an_out=1111, then 6 cycles of 1110 / 1101 / 1011 / 0111 respectively.
  - frame_done every 32 cycles; seg_out=seg_in during ON only.
- Leading-zero suppression: lz_suppress=1, load 16'h0050 ->
  - Digits 3 and 2: an_out stays 1111 and seg_out=0 for the full dwell.
  - Digit 1 shows nibble 5; digit 0 shows nibble 0.
  - Load 16'h0000 -> only digit 0 lit.
- Backpressure: scanning 16'h1111, load 16'h2222 mid-frame -> load_ready=0. Load 16'h3333 is held until ready.
  - 2222 appears from the next frame start.
  - ready rises the cycle after that boundary, 3333 is accepted, and it displays one frame later.
- Enable drop: enable=0 during ON of digit 2 -> an_out=1111 next cycle. Re-enable -> scan restarts at digit 0 BLANK with a pending value transferred.
- Async reset mid-dwell: reset_n=0 during ON of digit 1 -> an_out=1111 and seg_out=0 without a clock edge; display buffer=0 after release.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexes one shared hex decoder across NUM_DIGITS common-anode digits,
// double-buffering the displayed value so digits only change at frame boundaries.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    lz_suppress,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              nibble_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_END = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t                  r_state, w_state_nx;
    logic [IW-1:0]           r_idx, w_idx_nx;
    logic [CW-1:0]           r_cnt, w_cnt_nx;
    logic                    w_enter;
    logic [4*NUM_DIGITS-1:0] r_disp, r_pend, w_disp_nx;
    logic                    r_pend_full, r_supp, w_supp_nx, w_xfer, w_accept, w_lit;
    logic [3:0]              r_nibble;
    logic [NUM_DIGITS-1:0]   w_zero_from;

    // One counter spans the whole dwell: BLANK covers 0..BLANK_END, ON runs on to DWELL_END.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt + 1'b1;
        w_enter    = 1'b0;
        if (!enable) begin
            w_state_nx = IDLE;
            w_idx_nx   = '0;
            w_cnt_nx   = '0;
        end else if (r_state == IDLE) begin
            w_state_nx = BLANK;
            w_idx_nx   = '0;
            w_cnt_nx   = '0;
            w_enter    = 1'b1;
        end else if (r_state == BLANK) begin
            w_state_nx = (r_cnt == BLANK_END) ? ON : BLANK;
        end else if (r_cnt == DWELL_END) begin
            w_state_nx = BLANK;
            w_idx_nx   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            w_cnt_nx   = '0;
            w_enter    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign w_xfer    = w_enter && (w_idx_nx == '0) && r_pend_full;
    assign w_disp_nx = w_xfer ? r_pend : r_disp;
    assign w_accept  = load_valid && !r_pend_full;

    genvar g;
    for (g = 0; g < NUM_DIGITS; g++) begin : g_zero
        assign w_zero_from[g] = (w_disp_nx[4*NUM_DIGITS-1:4*g] == '0);
    end

    assign w_supp_nx = lz_suppress && (w_idx_nx != '0) && w_zero_from[w_idx_nx];

    // Nibble and suppression are latched on BLANK entry so the decoder settles while dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_nibble    <= '0;
            r_supp      <= 1'b0;
        end else begin
            r_disp <= w_disp_nx;
            if (w_enter) begin
                r_nibble <= w_disp_nx[4*w_idx_nx +: 4];
                r_supp   <= w_supp_nx;
            end
            if (w_accept) begin
                r_pend      <= load_data;
                r_pend_full <= 1'b1;
            end else if (w_xfer) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    assign w_lit      = (r_state == ON) && !r_supp;
    assign an_out     = w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
    assign seg_out    = w_lit ? seg_in : '0;
    assign nibble_out = r_nibble;
    assign load_ready = !r_pend_full;
    assign frame_done = (r_state == ON) && (r_idx == LAST_IDX) && (r_cnt == DWELL_END);
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: scoreboard bench; stimulus queues expected lit-digit and frame events,
// a monitor pops and compares them as the display presents them.
module tb_sevenseg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0, reset_n = 1'b1, enable = 1'b0, lz_suppress = 1'b0, load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready, frame_done;
    logic [3:0]  nibble_out, an_out;
    logic [6:0]  seg_in, seg_out;

    int n_chk = 0, n_err = 0;
    int mon_cyc = 0, mon_last_fd = 0;
    logic [3:0] mon_prev_an = 4'hf;

    typedef struct {bit fd; logic [3:0] an; logic [3:0] nib; int gap;} ev_t;
    ev_t q[$];

    sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .lz_suppress(lz_suppress),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .nibble_out(nibble_out), .seg_in(seg_in), .seg_out(seg_out),
        .an_out(an_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    assign seg_in = hex2seg(nibble_out);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_lit(input int k, input logic [3:0] nib);
        ev_t e;
        e.fd = 1'b0; e.an = ~(4'b0001 << k); e.nib = nib; e.gap = 0;
        q.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] d, input bit lz, input int gap);
        ev_t e;
        for (int k = 0; k < ND; k++)
            if (!(lz && k > 0 && (d >> (4*k)) == 16'h0)) push_lit(k, d[4*k +: 4]);
        e.fd = 1'b1; e.an = 4'hf; e.nib = 4'h0; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic do_load(input logic [15:0] d);
        int i = 0;
        load_data  = d;
        load_valid = 1'b1;
        while (load_ready !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("load_handshake_bound", 32'(i < 200), 1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_fd();
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (frame_done !== 1'b1 && i < 200);
        chk("frame_done_bound", frame_done, 1);
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (an_out !== pat && i < 200);
        chk("anode_wait_bound", an_out, pat);
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            mon_cyc++;
            chk("an_shape", 32'((an_out == 4'hf) || ($countones(~an_out) == 1)), 1);
            if (an_out == 4'hf) chk("seg_dark", seg_out, 0);
            else chk("seg_lit", seg_out, seg_in);
            if (an_out != 4'hf && mon_prev_an == 4'hf) begin
                if (q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL lit_unexpected: an=%b nibble=%h expected no event", an_out, nibble_out);
                end else begin
                    e = q.pop_front();
                    chk("lit_event_kind", e.fd, 0);
                    chk("lit_an", an_out, e.an);
                    chk("lit_nibble", nibble_out, e.nib);
                    chk("lit_seg", seg_out, hex2seg(e.nib));
                end
            end
            if (frame_done === 1'b1) begin
                if (q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL frame_unexpected: frame_done=1 expected no event");
                end else begin
                    e = q.pop_front();
                    chk("frame_event_kind", e.fd, 1);
                    if (e.gap != 0) chk("frame_gap", mon_cyc - mon_last_fd, e.gap);
                end
                mon_last_fd = mon_cyc;
            end
            mon_prev_an = an_out;
        end
    end

    initial begin : stimulus
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", an_out, 4'hf);
        chk("rst_seg", seg_out, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_nibble", nibble_out, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_an", an_out, 4'hf);
        chk("idle_ready", load_ready, 1);

        do_load(16'h1234);
        push_frame(16'h1234, 1'b0, 0);
        push_frame(16'h1234, 1'b0, ND*RD);
        enable = 1'b1;
        wait_fd();
        wait_fd();
        enable = 1'b0;
        @(negedge clk);
        chk("basic_stop_an", an_out, 4'hf);

        lz_suppress = 1'b1;
        do_load(16'h0050);
        push_frame(16'h0050, 1'b1, 0);
        push_frame(16'h0000, 1'b1, ND*RD);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        do_load(16'h0000);
        wait_fd();
        wait_fd();
        enable = 1'b0;
        lz_suppress = 1'b0;
        @(negedge clk);

        do_load(16'h1111);
        push_frame(16'h1111, 1'b0, 0);
        push_frame(16'h2222, 1'b0, ND*RD);
        push_frame(16'h3333, 1'b0, ND*RD);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        do_load(16'h2222);
        chk("bp_ready_low", load_ready, 0);
        load_data  = 16'h3333;
        load_valid = 1'b1;
        wait_fd();
        chk("bp_ready_low_at_boundary", load_ready, 0);
        @(negedge clk);
        chk("bp_ready_after_boundary", load_ready, 1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("bp_3333_accepted", load_ready, 0);
        wait_fd();
        wait_fd();
        enable = 1'b0;
        @(negedge clk);

        push_lit(0, 4'h3);
        push_lit(1, 4'h3);
        push_lit(2, 4'h3);
        enable = 1'b1;
        wait_an(4'b1011);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("disable_an", an_out, 4'hf);
        chk("disable_seg", seg_out, 0);
        do_load(16'h5678);
        push_frame(16'h5678, 1'b0, 0);
        push_lit(0, 4'h8);
        push_lit(1, 4'h7);
        enable = 1'b1;
        wait_fd();
        wait_an(4'b1101);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_an", an_out, 4'hf);
        chk("async_rst_seg", seg_out, 0);
        chk("async_rst_nibble", nibble_out, 0);
        chk("async_rst_ready", load_ready, 1);
        push_frame(16'h0000, 1'b0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_fd();
        enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
